// File: rtl/rvfi_retire_pkg.sv
// Shared types and helpers for the RVFI retire buffer: the queued record
// layout, the drop-counter width and the commit-group popcount.
package rvfi_retire_pkg;

    // Field widths of the queued record. The top-level XLEN/VLEN/OrderW
    // parameters are expected to match these; narrower values are zero-extended.
    localparam int unsigned CfgXlen        = 64;
    localparam int unsigned CfgVlen        = 64;
    localparam int unsigned CfgOrderW      = 64;

    // Upper bound on commit ports; popcount works on a vector this wide.
    localparam int unsigned MaxCommitPorts = 4;
    localparam int unsigned PortCntW       = 3;

    // Width of the saturating dropped-group counter.
    localparam int unsigned DropCntW       = 32;

    typedef struct packed {
        logic [CfgOrderW-1:0] order;
        logic [CfgVlen-1:0]   pc;
        logic [31:0]          insn;
        logic [4:0]           rd;
        logic [CfgXlen-1:0]   wdata;
        logic                 trap;
        logic [CfgXlen-1:0]   cause;
        logic [1:0]           priv;
    } rvfi_retire_rec_t;

    // Number of set bits in a (zero-extended) commit-valid vector.
    function automatic logic [PortCntW-1:0] popcount_ports(input logic [MaxCommitPorts-1:0] valid);
        logic [PortCntW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxCommitPorts; i++) begin
            cnt = cnt + PortCntW'(valid[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rvfi_retire_fifo.sv
// Circular record buffer: up to NrPorts writes per cycle into consecutive
// slots, one read per cycle from the head, occupancy tracked in a counter.
// The head is read combinationally so a record written at an edge is
// presented in the very next cycle.
module rvfi_retire_fifo
    import rvfi_retire_pkg::*;
#(
    parameter int unsigned Depth   = 16,
    parameter int unsigned NrPorts = 2,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned LevelW = $clog2(Depth) + 1,
    localparam int unsigned CntW   = $clog2(NrPorts + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [CntW-1:0]   wr_cnt_i,
    input  rvfi_retire_rec_t  wr_data_i [NrPorts],
    input  logic              pop_i,
    output rvfi_retire_rec_t  rd_data_o,
    output logic [LevelW-1:0] level_o
);

    rvfi_retire_rec_t  mem [Depth];
    logic [PtrW-1:0]   wr_ptr_reg;
    logic [PtrW-1:0]   rd_ptr_reg;
    logic [LevelW-1:0] level_reg;

    // Pointer and occupancy bookkeeping; flush drops queue state like a reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PtrW'(wr_cnt_i);
            rd_ptr_reg <= rd_ptr_reg + PtrW'(pop_i);
            level_reg  <= level_reg + LevelW'(wr_cnt_i) - LevelW'(pop_i);
        end
    end

    // Lane j of an accepted group lands at wr_ptr + j (pointers wrap naturally).
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NrPorts; j++) begin
            if (!rst_i && !flush_i && (CntW'(j) < wr_cnt_i)) begin
                mem[wr_ptr_reg + PtrW'(j)] <= wr_data_i[j];
            end
        end
    end

    assign rd_data_o = mem[rd_ptr_reg];
    assign level_o   = level_reg;

endmodule

// File: rtl/rvfi_retire_buffer.sv
// Retire buffer beside the commit stage: captures every retiring instruction,
// stamps it with a monotonic order number and queues it for the trace sink.
// Full-FIFO policy is either drop-whole-group-and-count or stall commit.
module rvfi_retire_buffer
    import rvfi_retire_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 64,
    parameter int unsigned Depth         = 16,
    parameter int unsigned OrderW        = 64,
    parameter bit          DropOnFull    = 1'b1,
    localparam int unsigned LevelW       = $clog2(Depth) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NrCommitPorts-1:0]            retire_valid_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]  retire_pc_i,
    input  logic [NrCommitPorts-1:0][31:0]      retire_insn_i,
    input  logic [NrCommitPorts-1:0][4:0]       retire_rd_i,
    input  logic [NrCommitPorts-1:0][XLEN-1:0]  retire_wdata_i,
    input  logic [NrCommitPorts-1:0]            retire_trap_i,
    input  logic [NrCommitPorts-1:0][XLEN-1:0]  retire_cause_i,
    input  logic [1:0]                          priv_lvl_i,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output rvfi_retire_rec_t                    trace_rec_o,
    output logic                                stall_o,
    output logic [DropCntW-1:0]                 drop_cnt_o,
    output logic [LevelW-1:0]                   level_o
);

    localparam int unsigned CntW = $clog2(NrCommitPorts + 1);

    logic [OrderW-1:0]         order_cnt_reg;
    logic [OrderW-1:0]         order_cnt_next;
    logic [DropCntW-1:0]       drop_cnt_reg;
    logic [DropCntW-1:0]       drop_cnt_next;
    logic [LevelW-1:0]         level;
    logic [LevelW-1:0]         free;
    logic [NrCommitPorts-1:0]  valid_eff;
    logic [MaxCommitPorts-1:0] valid_ext;
    logic [PortCntW-1:0]       group_n;
    logic                      accept;
    logic [CntW-1:0]           wr_cnt;
    logic                      pop;
    rvfi_retire_rec_t          head;
    logic [PortCntW-1:0]       port_slot [NrCommitPorts];
    rvfi_retire_rec_t          port_rec  [NrCommitPorts];
    rvfi_retire_rec_t          lane_rec  [NrCommitPorts];

    // Space is judged on the registered level only, so a same-cycle pop
    // never frees room and there is no path from the sink back into commit.
    assign free    = LevelW'(Depth) - level;
    assign stall_o = !DropOnFull && (32'(free) < NrCommitPorts);

    // Retires presented while stalled are a commit-side protocol error; ignore them.
    assign valid_eff = stall_o ? '0 : retire_valid_i;

    // Zero-extend the group valid vector to the popcount helper's width.
    always_comb begin
        valid_ext = '0;
        valid_ext[NrCommitPorts-1:0] = valid_eff;
    end

    assign group_n = popcount_ports(valid_ext);
    assign accept  = (32'(group_n) <= 32'(free));
    assign wr_cnt  = (accept && !flush_i) ? CntW'(group_n) : '0;
    assign pop     = trace_valid_o && trace_ready_i;

    // Per-port record build; a port's slot is the number of valid ports below it.
    for (genvar gi = 0; gi < NrCommitPorts; gi++) begin : gen_port
        localparam logic [MaxCommitPorts-1:0] LowerMask = MaxCommitPorts'((1 << gi) - 1);
        rvfi_retire_rec_t rec;

        assign port_slot[gi] = popcount_ports(valid_ext & LowerMask);

        // Stamp order and mask wdata/cause according to rd and trap.
        always_comb begin
            rec       = '0;
            rec.order = CfgOrderW'(order_cnt_reg + OrderW'(port_slot[gi]));
            rec.pc    = CfgVlen'(retire_pc_i[gi]);
            rec.insn  = retire_insn_i[gi];
            rec.rd    = retire_rd_i[gi];
            rec.wdata = ((retire_rd_i[gi] == 5'd0) || retire_trap_i[gi]) ? '0
                                                                         : CfgXlen'(retire_wdata_i[gi]);
            rec.trap  = retire_trap_i[gi];
            rec.cause = retire_trap_i[gi] ? CfgXlen'(retire_cause_i[gi]) : '0;
            rec.priv  = priv_lvl_i;
        end

        assign port_rec[gi] = rec;
    end

    // Compaction: write lane gi takes the valid port whose slot equals gi.
    for (genvar gi = 0; gi < NrCommitPorts; gi++) begin : gen_lane
        rvfi_retire_rec_t lane;

        // Pick the source port for this lane; unused lanes carry zeros.
        always_comb begin
            lane = '0;
            for (int k = 0; k < NrCommitPorts; k++) begin
                if (valid_eff[k] && (port_slot[k] == PortCntW'(gi))) begin
                    lane = port_rec[k];
                end
            end
        end

        assign lane_rec[gi] = lane;
    end

    rvfi_retire_fifo #(
        .Depth   (Depth),
        .NrPorts (NrCommitPorts)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .wr_cnt_i  (wr_cnt),
        .wr_data_i (lane_rec),
        .pop_i     (pop),
        .rd_data_o (head),
        .level_o   (level)
    );

    // Order advances for every non-empty group, accepted, dropped or flushed,
    // so gaps at the sink reveal lost records. Drops count only real drops.
    always_comb begin
        order_cnt_next = order_cnt_reg + OrderW'(group_n);
        drop_cnt_next  = drop_cnt_reg;
        if (DropOnFull && !flush_i && (group_n != '0) && !accept && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    // Order and drop counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            order_cnt_reg <= order_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    // Commit must hold off while stalled; flag any retire seen in that state.
    always_ff @(posedge clk_i) begin
        if (!rst_i && stall_o) begin
            assert (retire_valid_i == '0);
        end
    end

    assign trace_valid_o = (level != '0);
    assign trace_rec_o   = trace_valid_o ? head : '0;
    assign drop_cnt_o    = drop_cnt_reg;
    assign level_o       = level;

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Scoreboard bench for rvfi_retire_buffer: two instances (drop policy and
// stall policy, both Depth 4, two commit ports). Stimulus pushes expected
// records into per-instance queues; monitors pop and compare on each handshake.
`timescale 1ns/1ps
module tb_rvfi_retire_buffer;
    import rvfi_retire_pkg::*;

    localparam int NP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [NP-1:0][63:0]     pc;
    logic [NP-1:0][31:0]     insn;
    logic [NP-1:0][4:0]      rd;
    logic [NP-1:0][63:0]     wdata;
    logic [NP-1:0]           trap;
    logic [NP-1:0][63:0]     cause;
    logic [1:0]              priv;

    logic [NP-1:0]           valid_d, valid_s;
    logic                    flush_d, flush_s, ready_d, ready_s;
    logic                    tv_d, tv_s, stall_d, stall_s;
    rvfi_retire_rec_t        rec_d, rec_s;
    logic [31:0]             drop_d, drop_s;
    logic [2:0]              level_d, level_s;

    int total = 0;
    int bad   = 0;
    rvfi_retire_rec_t q_d[$];
    rvfi_retire_rec_t q_s[$];

    rvfi_retire_buffer #(
        .NrCommitPorts(NP), .XLEN(64), .VLEN(64), .Depth(4), .OrderW(64), .DropOnFull(1'b1)
    ) u_drop (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_d), .retire_valid_i(valid_d),
        .retire_pc_i(pc), .retire_insn_i(insn), .retire_rd_i(rd), .retire_wdata_i(wdata),
        .retire_trap_i(trap), .retire_cause_i(cause), .priv_lvl_i(priv),
        .trace_valid_o(tv_d), .trace_ready_i(ready_d), .trace_rec_o(rec_d),
        .stall_o(stall_d), .drop_cnt_o(drop_d), .level_o(level_d)
    );

    rvfi_retire_buffer #(
        .NrCommitPorts(NP), .XLEN(64), .VLEN(64), .Depth(4), .OrderW(64), .DropOnFull(1'b0)
    ) u_stall (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_s), .retire_valid_i(valid_s),
        .retire_pc_i(pc), .retire_insn_i(insn), .retire_rd_i(rd), .retire_wdata_i(wdata),
        .retire_trap_i(trap), .retire_cause_i(cause), .priv_lvl_i(priv),
        .trace_valid_o(tv_s), .trace_ready_i(ready_s), .trace_rec_o(rec_s),
        .stall_o(stall_s), .drop_cnt_o(drop_s), .level_o(level_s)
    );

    function automatic rvfi_retire_rec_t mk(input logic [63:0] o, input logic [63:0] p,
                                            input logic [31:0] i, input logic [4:0] r,
                                            input logic [63:0] w, input logic t,
                                            input logic [63:0] c, input logic [1:0] pl);
        rvfi_retire_rec_t x;
        x.order = o; x.pc = p; x.insn = i; x.rd = r;
        x.wdata = w; x.trap = t; x.cause = c; x.priv = pl;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input rvfi_retire_rec_t act, input rvfi_retire_rec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got order=%0d pc=%0h insn=%0h rd=%0d wdata=%0h trap=%0b cause=%0h priv=%0d want order=%0d pc=%0h insn=%0h rd=%0d wdata=%0h trap=%0b cause=%0h priv=%0d",
                     name, act.order, act.pc, act.insn, act.rd, act.wdata, act.trap, act.cause, act.priv,
                     exp.order, exp.pc, exp.insn, exp.rd, exp.wdata, exp.trap, exp.cause, exp.priv);
        end
    endtask

    // Monitor for the drop-policy instance: compare every accepted head record.
    always @(negedge clk) begin
        if (!rst && tv_d && ready_d) begin
            if (q_d.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_drop: got unexpected record order=%0d want none", rec_d.order);
            end else begin
                chk_rec("mon_drop", rec_d, q_d.pop_front());
            end
        end
    end

    // Monitor for the stall-policy instance.
    always @(negedge clk) begin
        if (!rst && tv_s && ready_s) begin
            if (q_s.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_stall: got unexpected record order=%0d want none", rec_s.order);
            end else begin
                chk_rec("mon_stall", rec_s, q_s.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [63:0] p, input logic [31:0] i, input logic [4:0] r,
                            input logic [63:0] w, input logic t, input logic [63:0] c);
        pc[k] = p; insn[k] = i; rd[k] = r; wdata[k] = w; trap[k] = t; cause[k] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_d = '0; valid_s = '0; flush_d = 1'b0; flush_s = 1'b0;
        ready_d = 1'b0; ready_s = 1'b0;
        tick(); tick();
        rst = 1'b0;
        q_d.delete(); q_s.delete();
    endtask

    // Drain one instance with ready high until its queue and output are empty.
    task automatic drain(input string name, input bit stall_inst);
        int n;
        n = 0;
        if (stall_inst) ready_s = 1'b1; else ready_d = 1'b1;
        while (n < 20 && (stall_inst ? (q_s.size() != 0 || tv_s) : (q_d.size() != 0 || tv_d))) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL %s: got drain timeout (records still pending) want empty within 20 cycles", name);
        end
        ready_s = 1'b0; ready_d = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        priv = 2'b11;
        for (int k = 0; k < NP; k++) set_port(k, 64'h0, 32'h13, 5'd0, 64'h0, 1'b0, 64'h0);
        do_reset();

        // Reset state.
        chk("rst_level", 64'(level_d), 64'd0);
        chk("rst_valid", 64'(tv_d), 64'd0);
        chk("rst_drop", 64'(drop_d), 64'd0);
        chk("rst_stall_drop", 64'(stall_d), 64'd0);
        chk("rst_stall_stall", 64'(stall_s), 64'd0);
        chk_rec("rst_rec", rec_d, '0);

        // Two single-port retires, sink always ready.
        ready_d = 1'b1;
        set_port(0, 64'h8000_0000, 32'h0010_0093, 5'd1, 64'h1, 1'b0, 64'h0);
        valid_d = 2'b01;
        q_d.push_back(mk(0, 64'h8000_0000, 32'h0010_0093, 5'd1, 64'h1, 1'b0, 64'h0, 2'b11));
        tick();
        chk("single_lvl1", 64'(level_d), 64'd1);
        chk("single_vld", 64'(tv_d), 64'd1);
        set_port(0, 64'h8000_0004, 32'h0020_0113, 5'd2, 64'h2, 1'b0, 64'h0);
        q_d.push_back(mk(1, 64'h8000_0004, 32'h0020_0113, 5'd2, 64'h2, 1'b0, 64'h0, 2'b11));
        tick();
        valid_d = '0;
        chk("single_lvl_pushpop", 64'(level_d), 64'd1);
        tick();
        chk("single_lvl0", 64'(level_d), 64'd0);
        chk("single_vld0", 64'(tv_d), 64'd0);
        drain("single_drain", 1'b0);

        // Port 1 alone goes to slot 0, then a full group in port order.
        do_reset();
        set_port(0, 64'h200, 32'h0030_0193, 5'd3, 64'h33, 1'b0, 64'h0);
        set_port(1, 64'h100, 32'h0040_0213, 5'd4, 64'h44, 1'b0, 64'h0);
        valid_d = 2'b10;
        q_d.push_back(mk(0, 64'h100, 32'h0040_0213, 5'd4, 64'h44, 1'b0, 64'h0, 2'b11));
        tick();
        chk_rec("dual_slot0", rec_d, mk(0, 64'h100, 32'h0040_0213, 5'd4, 64'h44, 1'b0, 64'h0, 2'b11));
        set_port(1, 64'h204, 32'h0050_0293, 5'd5, 64'h55, 1'b0, 64'h0);
        valid_d = 2'b11;
        q_d.push_back(mk(1, 64'h200, 32'h0030_0193, 5'd3, 64'h33, 1'b0, 64'h0, 2'b11));
        q_d.push_back(mk(2, 64'h204, 32'h0050_0293, 5'd5, 64'h55, 1'b0, 64'h0, 2'b11));
        tick();
        valid_d = '0;
        chk("dual_lvl3", 64'(level_d), 64'd3);
        drain("dual_drain", 1'b0);

        // Drop on full: four singles fill Depth 4, the next pair is dropped.
        do_reset();
        valid_d = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_port(0, 64'h1000 + 64'(4 * i), 32'h0000_0313, 5'd6, 64'h10 + 64'(i), 1'b0, 64'h0);
            q_d.push_back(mk(64'(i), 64'h1000 + 64'(4 * i), 32'h0000_0313, 5'd6, 64'h10 + 64'(i), 1'b0, 64'h0, 2'b11));
            tick();
        end
        chk("full_lvl4", 64'(level_d), 64'd4);
        set_port(0, 64'h2000, 32'h13, 5'd1, 64'h1, 1'b0, 64'h0);
        set_port(1, 64'h2004, 32'h13, 5'd2, 64'h2, 1'b0, 64'h0);
        valid_d = 2'b11;
        tick();
        valid_d = '0;
        chk("drop_cnt1", 64'(drop_d), 64'd1);
        chk("drop_lvl4", 64'(level_d), 64'd4);
        chk("drop_nostall", 64'(stall_d), 64'd0);
        drain("drop_drain", 1'b0);
        set_port(0, 64'h3000, 32'h0000_0393, 5'd7, 64'h77, 1'b0, 64'h0);
        valid_d = 2'b01;
        q_d.push_back(mk(6, 64'h3000, 32'h0000_0393, 5'd7, 64'h77, 1'b0, 64'h0, 2'b11));
        tick();
        valid_d = '0;
        chk_rec("drop_gap_order6", rec_d, mk(6, 64'h3000, 32'h0000_0393, 5'd7, 64'h77, 1'b0, 64'h0, 2'b11));
        drain("gap_drain", 1'b0);

        // Trap masking and hold stability with ready low (orders 7 and 8).
        set_port(0, 64'h4000, 32'h0000_0073, 5'd5, 64'hDEAD, 1'b1, 64'h2);
        set_port(1, 64'h4004, 32'h0000_0013, 5'd0, 64'h55, 1'b0, 64'h7);
        valid_d = 2'b11;
        q_d.push_back(mk(7, 64'h4000, 32'h0000_0073, 5'd5, 64'h0, 1'b1, 64'h2, 2'b11));
        q_d.push_back(mk(8, 64'h4004, 32'h0000_0013, 5'd0, 64'h0, 1'b0, 64'h0, 2'b11));
        tick();
        valid_d = '0;
        set_port(0, 64'h0, 32'h13, 5'd0, 64'h0, 1'b0, 64'h0);
        for (int c = 0; c < 3; c++) begin
            chk_rec("trap_hold", rec_d, mk(7, 64'h4000, 32'h0000_0073, 5'd5, 64'h0, 1'b1, 64'h2, 2'b11));
            chk("trap_hold_vld", 64'(tv_d), 64'd1);
            tick();
        end
        drain("trap_drain", 1'b0);

        // Flush with level 3 and a simultaneous pair: everything queued is lost.
        do_reset();
        set_port(0, 64'h5000, 32'h13, 5'd8, 64'h88, 1'b0, 64'h0);
        set_port(1, 64'h5004, 32'h13, 5'd9, 64'h99, 1'b0, 64'h0);
        valid_d = 2'b11;
        tick();
        set_port(0, 64'h5008, 32'h13, 5'd10, 64'hAA, 1'b0, 64'h0);
        valid_d = 2'b01;
        tick();
        chk("flush_pre_lvl3", 64'(level_d), 64'd3);
        valid_d = 2'b11;
        flush_d = 1'b1;
        tick();
        flush_d = 1'b0;
        valid_d = '0;
        chk("flush_lvl0", 64'(level_d), 64'd0);
        chk("flush_vld0", 64'(tv_d), 64'd0);
        chk("flush_drop0", 64'(drop_d), 64'd0);
        set_port(0, 64'h6000, 32'h13, 5'd11, 64'hBB, 1'b0, 64'h0);
        valid_d = 2'b01;
        q_d.push_back(mk(5, 64'h6000, 32'h13, 5'd11, 64'hBB, 1'b0, 64'h0, 2'b11));
        tick();
        valid_d = '0;
        chk_rec("flush_next_order5", rec_d, mk(5, 64'h6000, 32'h13, 5'd11, 64'hBB, 1'b0, 64'h0, 2'b11));
        drain("flush_drain", 1'b0);

        // Stall policy: stall rises at level 3 (free 1 < 2), clears after one pop.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_port(0, 64'h7000 + 64'(4 * i), 32'h13, 5'd12, 64'(i + 1), 1'b0, 64'h0);
            valid_s = 2'b01;
            q_s.push_back(mk(64'(i), 64'h7000 + 64'(4 * i), 32'h13, 5'd12, 64'(i + 1), 1'b0, 64'h0, 2'b11));
            tick();
            valid_s = '0;
            chk("stall_level", 64'(level_s), 64'(i + 1));
            chk("stall_flag", 64'(stall_s), (i == 2) ? 64'd1 : 64'd0);
        end
        ready_s = 1'b1;
        tick();
        chk("stall_after_pop_lvl", 64'(level_s), 64'd2);
        chk("stall_after_pop", 64'(stall_s), 64'd0);
        drain("stall_drain", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
